// File: rtl/cpu6_pipeline_drain_ctrl_if.sv
// ----------------------------------------------------------------------------
// cpu6_pipeline_drain_ctrl_if
//  Bundles the pipeline-drain request/status signals shared between the core
//  pipeline (master) and the drain controller (slave).
//  Signals:
//   empty_pipeline_reqE  core -> ctrl  EX instruction requests a full drain
//   redirect_flush       core -> ctrl  jump/trap redirect, kills a drain
//   mem_busy             core -> ctrl  data-memory access outstanding in MEM
//   stall_fd             ctrl -> core  freeze PC and IF/ID register
//   flush_e              ctrl -> core  insert bubble into ID/EX
//   drain_done           ctrl -> core  1-cycle pulse, resume next cycle
//   drain_timeout        ctrl -> core  with drain_done when exit was forced
//   busy                 ctrl -> core  controller not idle
// ----------------------------------------------------------------------------
interface cpu6_pipeline_drain_ctrl_if;
  logic empty_pipeline_reqE;
  logic redirect_flush;
  logic mem_busy;
  logic stall_fd;
  logic flush_e;
  logic drain_done;
  logic drain_timeout;
  logic busy;

  modport master (
    output empty_pipeline_reqE, redirect_flush, mem_busy,
    input  stall_fd, flush_e, drain_done, drain_timeout, busy
  );

  modport slave (
    input  empty_pipeline_reqE, redirect_flush, mem_busy,
    output stall_fd, flush_e, drain_done, drain_timeout, busy
  );
endinterface

// File: rtl/cpu6_pipeline_drain_ctrl.sv
// ----------------------------------------------------------------------------
// cpu6_pipeline_drain_ctrl
//  Sequences a full pipeline drain when the EX instruction requests it (CSR
//  write, fence). Holds fetch/decode and bubbles EX until the requester and
//  all older work have left MEM/WB, then pulses drain_done. A cumulative
//  mem_busy timer forces an exit (flagged by drain_timeout) if memory hangs.
//  Ports:
//   clk      core clock, all state on rising edge
//   reset    synchronous, active-low (0 = reset); outputs forced 0 while low
//   drainIf  slave side of cpu6_pipeline_drain_ctrl_if (request/status bus)
//  Parameters:
//   DRAIN_DEPTH  non-busy DRAIN cycles before DONE (1..2^CNT_W-1)
//   CNT_W        drain counter width
//   TIMEOUT      cumulative mem_busy DRAIN cycles before forced exit
//   TMO_W        timeout timer width
// ----------------------------------------------------------------------------
module cpu6_pipeline_drain_ctrl #(
  parameter int DRAIN_DEPTH = 2,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT     = 255,
  parameter int TMO_W       = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  cpu6_pipeline_drain_ctrl_if.slave    drainIf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEPTH_INIT = CNT_W'(DRAIN_DEPTH);
  localparam logic [TMO_W-1:0] TMR_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t            stateReg;
  logic [CNT_W-1:0]  cntReg;
  logic [TMO_W-1:0]  tmrReg;
  logic              tmoFlagReg;
  logic              start;

  // A redirect in the same cycle as the request means the requester is being
  // killed, so no drain is started.
  assign start = drainIf.empty_pipeline_reqE & ~drainIf.redirect_flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg   <= IDLE;
      cntReg     <= '0;
      tmrReg     <= '0;
      tmoFlagReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (start) begin
            stateReg   <= DRAIN;
            cntReg     <= DEPTH_INIT;
            tmrReg     <= '0;
            tmoFlagReg <= 1'b0;
          end
        end
        DRAIN: begin
          if (drainIf.redirect_flush) begin
            stateReg <= IDLE;
          end else if (drainIf.mem_busy) begin
            // Timer accumulates over the whole drain and the count of
            // clean cycles is frozen while memory is busy.
            if (tmrReg == TMR_LAST) begin
              stateReg   <= DONE;
              tmoFlagReg <= 1'b1;
            end else begin
              tmrReg <= tmrReg + 1'b1;
            end
          end else if (cntReg == CNT_ONE) begin
            stateReg <= DONE;
          end else begin
            cntReg <= cntReg - 1'b1;
          end
        end
        DONE: begin
          stateReg <= IDLE;
        end
        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  // Outputs are partly Mealy (IDLE start) and must drop to 0 as soon as
  // reset is asserted, so they are decoded combinationally.
  always_comb begin
    drainIf.stall_fd      = 1'b0;
    drainIf.flush_e       = 1'b0;
    drainIf.drain_done    = 1'b0;
    drainIf.drain_timeout = 1'b0;
    drainIf.busy          = 1'b0;
    if (reset) begin
      drainIf.busy = (stateReg != IDLE);
      case (stateReg)
        IDLE: begin
          drainIf.stall_fd = start;
          drainIf.flush_e  = start;
        end
        DRAIN: begin
          drainIf.stall_fd = 1'b1;
          drainIf.flush_e  = 1'b1;
        end
        DONE: begin
          drainIf.stall_fd      = 1'b1;
          drainIf.drain_done    = 1'b1;
          drainIf.drain_timeout = tmoFlagReg;
        end
        default: begin
          drainIf.stall_fd = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_pipeline_drain_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu6_pipeline_drain_ctrl
//  Table-driven bench for the drain controller. Two instances share inputs:
//  dutA uses default parameters, dutT uses TIMEOUT=4 for the forced-exit case.
//  Expected output word per cycle: {stall_fd, flush_e, drain_done,
//  drain_timeout, busy}.
// ----------------------------------------------------------------------------
module tb_cpu6_pipeline_drain_ctrl;

  logic clk;
  logic reset;
  logic reqE;
  logic redirect;
  logic memBusy;

  int checks;
  int errors;

  cpu6_pipeline_drain_ctrl_if ifA ();
  cpu6_pipeline_drain_ctrl_if ifT ();

  assign ifA.empty_pipeline_reqE = reqE;
  assign ifA.redirect_flush      = redirect;
  assign ifA.mem_busy            = memBusy;
  assign ifT.empty_pipeline_reqE = reqE;
  assign ifT.redirect_flush      = redirect;
  assign ifT.mem_busy            = memBusy;

  cpu6_pipeline_drain_ctrl dutA (
    .clk     (clk),
    .reset   (reset),
    .drainIf (ifA)
  );

  cpu6_pipeline_drain_ctrl #(
    .DRAIN_DEPTH (2),
    .CNT_W       (3),
    .TIMEOUT     (4),
    .TMO_W       (8)
  ) dutT (
    .clk     (clk),
    .reset   (reset),
    .drainIf (ifT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       req;
    logic       rf;
    logic       mb;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[80];
  int   nVec;

  function automatic logic [4:0] outsA();
    return {ifA.stall_fd, ifA.flush_e, ifA.drain_done, ifA.drain_timeout, ifA.busy};
  endfunction

  function automatic logic [4:0] outsT();
    return {ifT.stall_fd, ifT.flush_e, ifT.drain_done, ifT.drain_timeout, ifT.busy};
  endfunction

  task automatic addVec(input logic r, input logic q, input logic f,
                        input logic m, input logic [4:0] e);
    vecs[nVec].rst = r;
    vecs[nVec].req = q;
    vecs[nVec].rf  = f;
    vecs[nVec].mb  = m;
    vecs[nVec].exp = e;
    nVec++;
  endtask

  // Drive one cycle's inputs just after the rising edge, then settle to the
  // falling edge where outputs are sampled.
  task automatic driveCycle(input logic r, input logic q, input logic f, input logic m);
    @(posedge clk);
    #1;
    reset    = r;
    reqE     = q;
    redirect = f;
    memBusy  = m;
    @(negedge clk);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got {stall,flush,done,tmo,busy}=%b expected %b",
               name, idx, act, exp);
    end else begin
      $display("ok   %s[%0d] r=%b req=%b rf=%b mb=%b outs=%b",
               name, idx, reset, reqE, redirect, memBusy, act);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    nVec     = 0;
    reset    = 1'b0;
    reqE     = 1'b0;
    redirect = 1'b0;
    memBusy  = 1'b0;

    // Reset held with a request pending: everything stays low.
    addVec(0, 1, 0, 0, 5'b00000);
    addVec(0, 1, 0, 0, 5'b00000);
    addVec(1, 0, 0, 0, 5'b00000);
    // Plain drain, depth 2: start, 2x DRAIN, DONE, IDLE.
    addVec(1, 1, 0, 0, 5'b11000);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b10101);
    addVec(1, 0, 0, 0, 5'b00000);
    // mem_busy for 4 DRAIN cycles stretches the drain; no timeout.
    addVec(1, 1, 0, 0, 5'b11000);
    addVec(1, 0, 0, 1, 5'b11001);
    addVec(1, 0, 0, 1, 5'b11001);
    addVec(1, 0, 0, 1, 5'b11001);
    addVec(1, 0, 0, 1, 5'b11001);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b10101);
    addVec(1, 0, 0, 0, 5'b00000);
    // Redirect mid-drain aborts without drain_done.
    addVec(1, 1, 0, 0, 5'b11000);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 1, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b00000);
    // Request and redirect together: no drain.
    addVec(1, 1, 1, 0, 5'b00000);
    addVec(1, 0, 0, 0, 5'b00000);
    // Inputs ignored in DONE, then back-to-back request in the next IDLE.
    addVec(1, 1, 0, 0, 5'b11000);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 1, 1, 0, 5'b10101);
    addVec(1, 1, 0, 0, 5'b11000);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b10101);
    addVec(1, 0, 0, 0, 5'b00000);
    // mem_busy at cnt==1 holds the count.
    addVec(1, 1, 0, 0, 5'b11000);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 1, 5'b11001);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b10101);
    addVec(1, 0, 0, 0, 5'b00000);
    // Reset during DRAIN, then a fresh drain.
    addVec(1, 1, 0, 0, 5'b11000);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(0, 0, 0, 0, 5'b00000);
    addVec(1, 0, 0, 0, 5'b00000);
    addVec(1, 1, 0, 0, 5'b11000);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b11001);
    addVec(1, 0, 0, 0, 5'b10101);
    addVec(1, 0, 0, 0, 5'b00000);

    for (int i = 0; i < nVec; i++) begin
      driveCycle(vecs[i].rst, vecs[i].req, vecs[i].rf, vecs[i].mb);
      check("vec", i, outsA(), vecs[i].exp);
    end

    // Forced exit on dutT (TIMEOUT=4) with mem_busy stuck high; dutA, with
    // the default timeout, must still be draining when dutT finishes.
    driveCycle(0, 0, 0, 0);
    check("tmoRst", 0, outsT(), 5'b00000);
    driveCycle(1, 1, 0, 1);
    check("tmoStart", 0, outsT(), 5'b11000);
    for (int k = 0; k < 4; k++) begin
      driveCycle(1, 0, 0, 1);
      check("tmoDrain", k, outsT(), 5'b11001);
    end
    driveCycle(1, 0, 0, 1);
    check("tmoDone", 0, outsT(), 5'b10111);
    check("noTmoA", 0, outsA(), 5'b11001);
    driveCycle(1, 0, 0, 1);
    check("tmoIdle", 0, outsT(), 5'b00000);

    // A later normal drain on dutT must not carry the old timeout flag.
    driveCycle(0, 0, 0, 0);
    driveCycle(1, 1, 0, 0);
    driveCycle(1, 0, 0, 0);
    driveCycle(1, 0, 0, 0);
    driveCycle(1, 0, 0, 0);
    check("tmoClear", 0, outsT(), 5'b10101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
